ppu_fb_writer: RTL
==================

Name: ppu_fb_writer

Overview:
Downstream consumer of the PPU pixel stream (PX_OUT/PX_valid). Maps each 2-bit colour index through BGP and tracks the (x, y) screen position from PPU_MODE transitions. Writes shaded pixels into a double-banked 160x144 framebuffer through a small elastic FIFO, so framebuffer backpressure never stalls the PPU. The display side reads the bank this block is not writing.

Parameters:
SCREEN_W, 160, pixels per line
SCREEN_H, 144, visible lines per frame
FIFO_DEPTH, 8, write-buffer entries (power of 2, >=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
PX_OUT  in  2  pixel colour index from PPU
PX_valid  in  1  PX_OUT valid this cycle
PPU_MODE  in  2  PPU mode: 0=H_BLANK, 1=V_BLANK, 2=SCAN, 3=DRAW
BGP  in  8  background palette register (FF47)
FB_WE  out  1  framebuffer write request
FB_ADDR  out  16  linear framebuffer address
FB_DATA  out  2  shade to write
FB_READY  in  1  framebuffer accepts write when FB_WE&&FB_READY
DISP_BANK  out  1  bank the display should read (complement of write bank)
FRAME_DONE  out  1  one-cycle pulse at frame completion
OVERFLOW  out  1  sticky: pixel lost to full FIFO
LINE_OVERRUN  out  1  sticky: more than SCREEN_W pixels in a line

Behaviour:
- Reset (rst low, async): x=0, y=0, wr_bank=0, FIFO empty, palette stage invalid. All outputs 0: FB_WE, FB_ADDR, FB_DATA, DISP_BANK=1 (complement of wr_bank), FRAME_DONE, OVERFLOW, LINE_OVERRUN. Reset mid-frame discards all buffered pixels.
- Mode edge detect: prev_mode register; events are evaluated on (prev_mode != PPU_MODE).
- DRAW entry: x <= 0.
- DRAW exit (prev=DRAW, now != DRAW): if x != 0 and y < SCREEN_H-1, y <= y+1.
- V_BLANK entry:
  - y <= 0, x <= 0.
  - wr_bank toggles; DISP_BANK updates in the same cycle.
  - FRAME_DONE high for exactly one cycle.
  - V_BLANK entry with no pixels written since the last toggle still toggles.
- Pixel path, stage 1 (cycle n+1 after a PX_valid cycle n, valid only while PPU_MODE==DRAW):
  - shade = BGP[2*PX_OUT+1 : 2*PX_OUT], using BGP as sampled at cycle n.
  - addr = wr_bank*SCREEN_W*SCREEN_H + y*SCREEN_W + x, computed in 16 bits (max 46079).
  - x increments.
- Pixels with x >= SCREEN_W are not enqueued: x saturates at SCREEN_W and LINE_OVERRUN sets.
- PX_valid outside DRAW is ignored with no flag.
- FIFO: entries are {addr, shade}; stage 1 pushes; the head drives FB_ADDR/FB_DATA.
  - FB_WE = !empty.
  - Pop on FB_WE && FB_READY.
  - Minimum latency: PX_valid at n gives FB_WE at n+2 when FIFO was empty.
  - FB_ADDR and FB_DATA hold stable while FB_WE && !FB_READY.
- Full FIFO:
  - Push while full and not popping in the same cycle: pixel dropped, OVERFLOW set; x still advances so later addresses stay correct.
  - Push and pop in the same cycle while full: accepted, no overflow.
- Sticky flags clear only on reset.
- Queued writes drain after bank toggle to their original (old-bank) addresses. This is allowed because the addresses are already bank-qualified.
- Counter wrap: y never exceeds SCREEN_H-1; excess DRAW exits hold y.

Decomposition:
- Shared package ppu_pkg:
  - PPU_MODE enum (H_BLANK, V_BLANK, SCAN, DRAW with encodings 0-3), shared with the PPU.
  - SCREEN_W, SCREEN_H.
  - FB_BANK_SIZE = 23040.
- One sub-module: ppu_px_fifo, a synchronous FIFO with parameterised width/depth and push/pop/full/empty. It pushes and pops in the same cycle when full.
- Palette mapping, position counters and flags stay in the top.

Test Plan:
- Reset release, BGP=8'hE4, DRAW entry, 160 PX_valid with PX_OUT=i%4, FB_READY=1 -> 160 writes to addr 0..159, FB_DATA=i%4, first FB_WE 2 cycles after first PX_valid.
- BGP=8'h1B, PX_OUT=0,1,2,3 -> FB_DATA=3,2,1,0.
- 3 full lines then V_BLANK entry -> line 2 addr starts at 320, FRAME_DONE pulses once, DISP_BANK 1->0, next frame pixel (0,0) writes addr 23040.
- FB_READY=0 for 20 cycles during a line, FIFO_DEPTH=8 -> exactly 8 entries held, OVERFLOW=1, addresses after the stall continue at the correct x (no shift).
- FB_READY toggling 1/0 each cycle during a 160-pixel line -> no loss below FIFO capacity, FB_ADDR/FB_DATA stable during every stalled cycle, writes in order.
- 170 PX_valid in one DRAW period -> 160 writes, LINE_OVERRUN=1; assert rst low mid-line -> FB_WE drops immediately, flags clear, next frame starts at addr 0.

Source files
------------

// File: rtl/ppu_pkg.sv
// Definitions shared between the PPU and its downstream consumers.
// Covers the PPU mode encoding, the screen geometry and the palette lookup.
package ppu_pkg;

    typedef enum logic [1:0] {
        H_BLANK = 2'd0,
        V_BLANK = 2'd1,
        SCAN    = 2'd2,
        DRAW    = 2'd3
    } ppu_mode_e;

    localparam int SCREEN_W     = 160;
    localparam int SCREEN_H     = 144;
    localparam int FB_BANK_SIZE = 23040;
    localparam int FB_ADDR_W    = 16;

    // BGP holds four 2-bit shades; colour index i selects bits [2i+1:2i].
    function automatic logic [1:0] bgp_shade(input logic [7:0] bgp, input logic [1:0] idx);
        logic [1:0] shade;
        case (idx)
            2'd0:    shade = bgp[1:0];
            2'd1:    shade = bgp[3:2];
            2'd2:    shade = bgp[5:4];
            default: shade = bgp[7:6];
        endcase
        return shade;
    endfunction

endpackage

// File: rtl/ppu_px_fifo.sv
// Small synchronous FIFO that buffers pixel writes ahead of the framebuffer.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module ppu_px_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ppu_fb_writer.sv
// Shades the PPU pixel stream through BGP and writes it into a double-banked
// framebuffer via an elastic FIFO, tracking screen position from PPU mode edges.
module ppu_fb_writer
    import ppu_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  PX_OUT,
    input  logic        PX_valid,
    input  logic [1:0]  PPU_MODE,
    input  logic [7:0]  BGP,
    output logic        FB_WE,
    output logic [15:0] FB_ADDR,
    output logic [1:0]  FB_DATA,
    input  logic        FB_READY,
    output logic        DISP_BANK,
    output logic        FRAME_DONE,
    output logic        OVERFLOW,
    output logic        LINE_OVERRUN
);

    localparam int ENTRY_W = FB_ADDR_W + 2;

    ppu_mode_e    mode;
    ppu_mode_e    prev_mode;
    logic [7:0]   x;
    logic [7:0]   y;
    logic         wr_bank;

    logic         mode_chg;
    logic         draw_entry;
    logic         draw_exit;
    logic         vblank_entry;
    logic         px_take;
    logic [7:0]   x_cur;
    logic         x_in_range;
    logic [15:0]  px_addr;

    logic         s1_valid;
    logic [15:0]  s1_addr;
    logic [1:0]   s1_shade;

    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_pop;
    logic [ENTRY_W-1:0] fifo_dout;

    assign mode         = ppu_mode_e'(PPU_MODE);
    assign mode_chg     = (mode != prev_mode);
    assign draw_entry   = mode_chg && (mode == DRAW);
    assign draw_exit    = mode_chg && (prev_mode == DRAW);
    assign vblank_entry = mode_chg && (mode == V_BLANK);
    assign px_take      = PX_valid && (mode == DRAW);

    // A pixel arriving on the DRAW entry cycle already belongs at x=0.
    assign x_cur      = draw_entry ? 8'd0 : x;
    assign x_in_range = (x_cur < 8'(SCREEN_W));
    assign px_addr    = (wr_bank ? 16'(FB_BANK_SIZE) : 16'd0)
                      + 16'(y) * 16'(SCREEN_W) + 16'(x_cur);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_mode    <= H_BLANK;
            x            <= '0;
            y            <= '0;
            wr_bank      <= 1'b0;
            FRAME_DONE   <= 1'b0;
            LINE_OVERRUN <= 1'b0;
        end else begin
            prev_mode  <= mode;
            FRAME_DONE <= vblank_entry;
            if (vblank_entry) begin
                x       <= '0;
                y       <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                if (draw_exit && (x != 8'd0) && (y < 8'(SCREEN_H - 1))) y <= y + 8'd1;
                if (px_take) begin
                    if (x_in_range) begin
                        x <= x_cur + 8'd1;
                    end else begin
                        x            <= 8'(SCREEN_W);
                        LINE_OVERRUN <= 1'b1;
                    end
                end else if (draw_entry) begin
                    x <= '0;
                end
            end
        end
    end

    // Stage 1 holds the shaded pixel and its bank-qualified address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_shade <= '0;
        end else begin
            s1_valid <= px_take && x_in_range;
            if (px_take && x_in_range) begin
                s1_addr  <= px_addr;
                s1_shade <= bgp_shade(BGP, PX_OUT);
            end
        end
    end

    assign fifo_pop = FB_WE && FB_READY;

    ppu_px_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s1_valid),
        .din   ({s1_addr, s1_shade}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            OVERFLOW <= 1'b0;
        end else if (s1_valid && fifo_full && !fifo_pop) begin
            OVERFLOW <= 1'b1;
        end
    end

    assign FB_WE              = !fifo_empty;
    assign {FB_ADDR, FB_DATA} = fifo_empty ? '0 : fifo_dout;
    assign DISP_BANK          = ~wr_bank;

endmodule
